johnson_counter_param: RTL

- Parametrised Johnson (twisted-ring) counter.
- Adds to the fixed 4-bit twisted-ring counter:
  - configurable width
  - up/down direction
  - runtime Johnson/ring mode select
  - parallel load and count enable
  - illegal-state detection with optional self-correction
  - decoded phase index and terminal-count strobe
- Used as a multi-phase sequencer and clock-phase generator in counter/timing subsystems.

---
 rtl/johnson_counter_param_pkg.sv | 13 +
 rtl/johnson_counter_param_if.sv | 30 +++
 rtl/johnson_counter_param_jc_state_decode.sv | 55 +++++
 rtl/johnson_counter_param.sv | 70 +++++++
 4 files changed

// File: rtl/johnson_counter_param_pkg.sv
// rtl/johnson_counter_param_pkg.sv - shared constants and helpers for the parametrised Johnson counter
package johnson_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;
    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;

    function automatic int phase_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/johnson_counter_param_if.sv
// rtl/johnson_counter_param_if.sv - control and status bundle of the Johnson counter
interface johnson_counter_param_if
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int PW = phase_width(WIDTH);

    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [PW-1:0]    phase;
    logic             tc;
    logic             err;

    modport master (
        output en, dir, mode, load, load_val,
        input  q, qbar, phase, tc, err
    );

    modport slave (
        input  en, dir, mode, load, load_val,
        output q, qbar, phase, tc, err
    );

endinterface

// File: rtl/johnson_counter_param_jc_state_decode.sv
// rtl/johnson_counter_param_jc_state_decode.sv - legality check and phase index decode of the counter state
module jc_state_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = phase_width(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic             err,
    output logic [PW-1:0]    phase
);

    int   ones;
    int   trans;
    int   hot;
    int   idx;
    logic illegal;

    always_comb begin
        ones    = 0;
        trans   = 0;
        hot     = 0;
        idx     = 0;
        illegal = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) begin
                ones = ones + 1;
                hot  = i;
            end
        end
        // A Johnson pattern has at most one 0/1 boundary between neighbouring bits.
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q[i] ^ q[i+1]) begin
                trans = trans + 1;
            end
        end
        if (mode == MODE_RING) begin
            illegal = (ones != 1);
            idx     = hot;
        end else begin
            illegal = (trans > 1);
            if (q[0]) begin
                idx = ones;
            end else if (ones == 0) begin
                idx = 0;
            end else begin
                idx = 2 * WIDTH - ones;
            end
        end
        err   = illegal;
        phase = illegal ? '0 : PW'(idx);
    end

endmodule

// File: rtl/johnson_counter_param.sv
// rtl/johnson_counter_param.sv - Johnson/ring counter with direction, load, self-correction and phase decode
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1
) (
    input  logic                       clk,
    input  logic                       clr,
    johnson_counter_param_if.slave     bus
);

    localparam int             PW     = phase_width(WIDTH);
    localparam logic [PW-1:0]  LAST_J = PW'(2 * WIDTH - 1);
    localparam logic [PW-1:0]  LAST_R = PW'(WIDTH - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rst_pat;
    logic [WIDTH-1:0] shifted;
    logic [PW-1:0]    phase;
    logic             err;
    logic             terminal;

    jc_state_decode #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_decode (
        .q     (q),
        .mode  (bus.mode),
        .err   (err),
        .phase (phase)
    );

    always_comb begin
        rst_pat = (bus.mode == MODE_RING) ? WIDTH'(1) : '0;
        shifted = q;
        if (bus.mode == MODE_RING) begin
            if (bus.dir == DIR_UP) shifted = {q[WIDTH-2:0], q[WIDTH-1]};
            else                   shifted = {q[0], q[WIDTH-1:1]};
        end else begin
            if (bus.dir == DIR_UP) shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
            else                   shifted = {~q[0], q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= rst_pat;
        end else if (bus.load) begin
            q <= bus.load_val;
        end else if (bus.en) begin
            if (SELF_CORRECT && err) q <= rst_pat;
            else                     q <= shifted;
        end
    end

    always_comb begin
        terminal = 1'b0;
        if (bus.dir == DIR_UP) terminal = (phase == ((bus.mode == MODE_RING) ? LAST_R : LAST_J));
        else                   terminal = (phase == '0);
    end

    // tc flags the step that wraps the sequence, so it is suppressed when clr/load pre-empt the step.
    assign bus.tc    = bus.en & ~clr & ~bus.load & ~err & terminal;
    assign bus.q     = q;
    assign bus.qbar  = ~q;
    assign bus.phase = phase;
    assign bus.err   = err;

endmodule
